// File: rtl/serial_pkg.sv
// Shared constants and types for the serial receive path.
// The counter helper keeps the half-bit load arithmetic in one place.
package serial_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_BRKWAIT = 3'd4;

    localparam int DATA_BITS_SHORT = 8;
    localparam int DATA_BITS_LONG  = 9;
    localparam int PER_LONG_BIT    = 15;
    localparam int FRAME_W         = 9;

    typedef logic [FRAME_W-1:0] frame_t;

    // Counter expires at zero, so a wait of N clocks loads N-1.
    // Returns max(T>>1,1)-1 where T = p+1 (T may be 32768, hence 16-bit math).
    function automatic logic [14:0] half_load(input logic [14:0] p);
        logic [15:0] t;
        logic [15:0] h;
        t = {1'b0, p} + 16'd1;
        h = t >> 1;
        if (h == 16'd0) h = 16'd1;
        return 15'(h - 16'd1);
    endfunction

endpackage

// File: rtl/serial_rx_capture_if.sv
// Frame stream and status bundle between the receiver and its consumer.
interface serial_rx_capture_if;
    import serial_pkg::*;

    frame_t data_o;
    logic   valid_o;
    logic   ready_i;
    logic   ovrun_o;
    logic   frmerr_o;
    logic   brk_o;
    logic   clr_err_i;
    logic   busy_o;

    modport master (
        output data_o, valid_o, ovrun_o, frmerr_o, brk_o, busy_o,
        input  ready_i, clr_err_i
    );

    modport slave (
        input  data_o, valid_o, ovrun_o, frmerr_o, brk_o, busy_o,
        output ready_i, clr_err_i
    );

endinterface

// File: rtl/serial_rx_fifo.sv
// Show-ahead frame FIFO; a push while full is taken only alongside a pop.
// dout is registered so it holds the last head once the FIFO drains.
module serial_rx_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  frame_t din,
    input  logic   pop,
    output frame_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    frame_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_next;
    logic [CW-1:0]   count;
    logic            wr_en;
    logic            rd_en;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);
    assign rd_next = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_next;
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // New head is the incoming frame only when nothing older survives.
            if (wr_en && (empty || (rd_en && count == CW'(1))))
                dout <= din;
            else if (rd_en && count > CW'(1))
                dout <= mem[rd_next];
        end
    end

endmodule

// File: rtl/serial_rx_capture.sv
// Serial line receiver: synchroniser, bit-timing FSM and frame FIFO.
// Bit timing is taken from per, latched at the start edge of each frame.
module serial_rx_capture
    import serial_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          per,
    input  logic                 rxd,
    serial_rx_capture_if.master  rx
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic                   rs_prev;
    logic [2:0]             state;
    logic [15:0]            per_q;
    logic [14:0]            cnt;
    logic [3:0]             bit_idx;
    frame_t                 shreg;
    frame_t                 frame;
    logic                   expire;
    logic                   long_q;
    logic                   last_bit;
    logic                   push;
    logic                   stop_bad;
    logic                   pop_fire;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   brk_q;
    logic                   ovrun_q;
    logic                   frmerr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '1;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
    assign rs = sync_q[SYNC_STAGES-1];

    assign expire   = (cnt == '0);
    assign long_q   = per_q[PER_LONG_BIT];
    assign last_bit = (bit_idx == (long_q ? 4'(DATA_BITS_LONG - 1) : 4'(DATA_BITS_SHORT - 1)));
    // Bits enter at the top, so a short frame sits one place higher than a long one.
    assign frame    = long_q ? shreg : {1'b0, shreg[FRAME_W-1:1]};
    assign push     = (state == ST_STOP) && expire && rs;
    assign stop_bad = (state == ST_STOP) && expire && !rs;
    assign pop_fire = rx.valid_o && rx.ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            rs_prev <= 1'b1;
            per_q   <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rs_prev <= rs;
            case (state)
                ST_IDLE: begin
                    if (rs_prev && !rs) begin
                        per_q <= per;
                        cnt   <= half_load(per[14:0]);
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (!expire) begin
                        cnt <= cnt - 15'd1;
                    end else if (rs) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt     <= per_q[14:0];
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!expire) begin
                        cnt <= cnt - 15'd1;
                    end else begin
                        shreg <= {rs, shreg[FRAME_W-1:1]};
                        cnt   <= per_q[14:0];
                        if (last_bit) state   <= ST_STOP;
                        else          bit_idx <= bit_idx + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (!expire) cnt   <= cnt - 15'd1;
                    else         state <= rs ? ST_IDLE : ST_BRKWAIT;
                end
                ST_BRKWAIT: begin
                    if (rs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Error sets take priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brk_q    <= 1'b0;
            ovrun_q  <= 1'b0;
            frmerr_q <= 1'b0;
        end else begin
            if (stop_bad && frame == '0)          brk_q <= 1'b1;
            else if (state == ST_BRKWAIT && rs)   brk_q <= 1'b0;

            if (push && fifo_full && !pop_fire)   ovrun_q <= 1'b1;
            else if (rx.clr_err_i)                ovrun_q <= 1'b0;

            if (stop_bad)                         frmerr_q <= 1'b1;
            else if (rx.clr_err_i)                frmerr_q <= 1'b0;
        end
    end

    serial_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (frame),
        .pop     (rx.ready_i),
        .dout    (rx.data_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rx.valid_o  = !fifo_empty;
    assign rx.ovrun_o  = ovrun_q;
    assign rx.frmerr_o = frmerr_q;
    assign rx.brk_o    = brk_q;
    assign rx.busy_o   = (state != ST_IDLE);

endmodule

// File: doc/serial_rx_capture.md
Name: serial_rx_capture

Overview:
- Stand-alone receiver for the Paula-compatible serial line: the far end of the UART's txd output.
- Deserialises start / 8-or-9 data / stop frames at the SERPER-defined bit rate and buffers them in a small FIFO.
- Delivers frames over a valid/ready stream, for the host debug console and for loop-back checking in the serial bench.
- Reports overrun, framing error and break.

Parameters:
- DEPTH, 4, FIFO depth in frames; power of two, 2..16.
- SYNC_STAGES, 2, rxd synchroniser flops (≥2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- per  in  16  bit 15 = LONG (9 data bits); bits 14:0 = period; bit time T = per[14:0]+1 clocks
- rxd  in  1  serial input, idle high, asynchronous to clk
- data_o  out  9  FIFO head frame; bit 8 is 0 in 8-bit mode
- valid_o  out  1  FIFO not empty
- ready_i  in  1  consumer accepts head when valid_o&&ready_i
- ovrun_o  out  1  sticky: frame dropped because FIFO full
- frmerr_o  out  1  sticky: stop bit sampled low
- brk_o  out  1  break condition active
- clr_err_i  in  1  clears ovrun_o and frmerr_o
- busy_o  out  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (async, reset_n=0): state IDLE, synchroniser all 1, FIFO empty, data_o=0, valid_o=0, ovrun_o=0, frmerr_o=0, brk_o=0, busy_o=0. Reset mid-frame discards the partial frame.
- rxd passes through SYNC_STAGES flops; all timing below is relative to the synchronised signal rs.
- States: IDLE, START, DATA, STOP, BRKWAIT.
- IDLE: on rs 1→0, latch per into a working copy (per changes mid-frame have no effect). Load down-counter with max(T>>1,1). Go to START.
- START: at counter expiry, sample rs.
  - rs=1: false start, back to IDLE, nothing pushed.
  - rs=0: load T, bit index 0, go to DATA.
- DATA: at each expiry, shift rs into data LSB-first and reload T.
  - After 8 bits (LONG=0) or 9 bits (LONG=1), go to STOP.
- STOP: at expiry, sample rs.
  - rs=1: push frame, go to IDLE. A new start edge may then be detected from the next cycle.
  - rs=0: set frmerr_o, do not push, go to BRKWAIT. Additionally assert brk_o if all data bits were 0.
- BRKWAIT: stay until rs=1. Then clear brk_o and go to IDLE. No start detection occurs while in BRKWAIT.
- Push latency: valid_o rises the cycle after the stop-bit sample clock edge (FIFO state is registered). data_o is show-ahead, valid the same cycle as valid_o.
- FIFO pop on valid_o&&ready_i. data_o holds its value while valid_o=0.
- Push when full:
  - With a simultaneous pop: accepted, count unchanged, no overrun.
  - Without a pop: frame dropped, ovrun_o set, FIFO contents untouched.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- clr_err_i in the same cycle as a new error event: the set wins.
- per[14:0]=0: T=1, half-bit=1; must function at this setting, no divide-by-zero.
- Counter is 15 bits; T up to 32768 without overflow.

Decomposition:
- Package serial_pkg: state enum; bit-count constants DATA_BITS_SHORT=8 and DATA_BITS_LONG=9; PER_LONG_BIT=15.
- One sub-module: serial_rx_fifo. Synchronous, show-ahead FIFO with parameter DEPTH and width 9; outputs full/empty; accepts push-when-full-with-pop.
- Synchroniser and FSM stay in the top module.

Test Plan:
- Short frame: per=0x0010 (T=17), 8-bit frame 0xAA (line pattern of SERDAT 0x01AA) with stop high → one push, data_o=0x0AA, valid_o=1, flags 0; bench checks each data sample lands 8 or 9 clocks after the bit's mid-point reference.
- Long frame: per=0x8010, 9-bit frame 0x1AA (SERDAT 0x03AA) → data_o=0x1AA. Also change per to 0x0004 during DATA → no effect on this frame's timing.
- Glitch: rxd low for 5 clocks at per=0x0010 → false start, busy_o returns to 0, no push.
- Overrun: ready_i=0, send DEPTH+1=5 frames 0x01..0x05 → FIFO holds 0x01..0x04 and ovrun_o=1. Pulse clr_err_i → 0. Then a same-cycle push+pop on a full FIFO → no overrun, order preserved.
- Break: rxd held low 300 clocks at per=0x0010 → frmerr_o=1, brk_o=1 and held. rxd high → brk_o=0 the cycle after rs rises; the next valid frame 0x55 is received correctly.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 → all outputs 0 immediately. After release, a frame 0x3C is received cleanly.
